// File: rtl/exec_muldiv_iter.sv
// exec_muldiv_iter: iterative multiply/divide unit with valid/ready handshakes and flush
module exec_muldiv_iter #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [IALU_WORD_WIDTH-1:0] in_src1,
    input  logic [IALU_WORD_WIDTH-1:0] in_src2,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic                       out_div_by_zero,
    output logic                       out_busy
);
    localparam int W = IALU_WORD_WIDTH;
    localparam int N = W / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*W-1:0]     acc_q, acc_d, acc_step, prod_s;
    logic [W-1:0]       opnd_q, opnd_d, res_q, res_d, quo_s, rem_s, calc_res;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d, dbz_q, dbz_d;
    logic [REG_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [W:0]         sum;
    logic               accept, in_is_div, in_signed, s1, s2, in_dbz, in_exc, in_neg;
    logic [W-1:0]       mag1, mag2, exc_res;

    assign in_ready        = !in_flush && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept          = in_valid && in_ready;
    assign out_valid       = state_q == DONE;
    assign out_busy        = state_q != IDLE;
    assign out_res         = res_q;
    assign out_res_reg_idx = idx_q;
    assign out_div_by_zero = dbz_q;

    // Decode the offered op: operand magnitudes, result sign, and ops that skip iteration
    always_comb begin
        in_is_div = in_op >= 3'd3 && in_op <= 3'd6;
        in_signed = in_op == 3'd1 || in_op == 3'd3 || in_op == 3'd5;
        s1        = in_signed && in_src1[W-1];
        s2        = in_signed && in_src2[W-1];
        mag1      = s1 ? -in_src1 : in_src1;
        mag2      = s2 ? -in_src2 : in_src2;
        in_neg    = in_op == 3'd5 ? s1 : s1 ^ s2;
        in_dbz    = in_is_div && in_src2 == '0;
        in_exc    = in_dbz || in_op == 3'd7;
        exc_res   = in_op == 3'd7 ? '0 : in_op < 3'd5 ? '1 : in_src1;
    end

    // One iteration: BITS_PER_CYCLE shift-add or restoring-subtract steps on the 2W accumulator
    always_comb begin
        acc_step = acc_q;
        sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q >= 3'd3) begin
                sum = acc_step[2*W-1:W-1] - {1'b0, opnd_q};
                acc_step = sum[W] ? {acc_step[2*W-2:0], 1'b0} : {sum[W-1:0], acc_step[W-2:0], 1'b1};
            end else begin
                sum = {1'b0, acc_step[2*W-1:W]} + (acc_step[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
                acc_step = {sum, acc_step[W-1:1]};
            end
        end
        prod_s   = neg_q ? -acc_step : acc_step;
        quo_s    = neg_q ? -acc_step[W-1:0] : acc_step[W-1:0];
        rem_s    = neg_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        calc_res = op_q == 3'd0 ? acc_step[W-1:0] : op_q < 3'd3 ? prod_s[2*W-1:W] : op_q < 3'd5 ? quo_s : rem_s;
    end

    // Next-state: flush beats accept, accept beats drain, otherwise iterate
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        res_d   = res_q;
        idx_d   = idx_q;
        dbz_d   = dbz_q;
        if (in_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = '0;
            idx_d   = '0;
            dbz_d   = 1'b0;
        end else if (accept) begin
            state_d = in_exc ? DONE : CALC;
            cnt_d   = '0;
            acc_d   = {{W{1'b0}}, in_is_div ? mag1 : mag2};
            opnd_d  = in_is_div ? mag2 : mag1;
            op_d    = in_op;
            neg_d   = in_neg;
            idx_d   = in_res_reg_idx;
            dbz_d   = in_dbz;
            res_d   = in_exc ? exc_res : res_q;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end else if (state_q == CALC) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            state_d = cnt_q == CW'(N - 1) ? DONE : CALC;
            res_d = cnt_q == CW'(N - 1) ? calc_res : res_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            idx_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_exec_muldiv_iter.sv
// tb_exec_muldiv_iter: directed stimulus with a queue scoreboard and independent result monitor
module tb_exec_muldiv_iter;
    localparam int N = 16;

    logic        clock = 0, reset = 1;
    logic        in_valid = 0, in_ready, in_flush = 0;
    logic [2:0]  in_op = 0;
    logic [15:0] in_src1 = 0, in_src2 = 0;
    logic [3:0]  in_res_reg_idx = 0;
    logic        out_valid, out_ready = 1;
    logic [15:0] out_res;
    logic [3:0]  out_res_reg_idx;
    logic        out_div_by_zero, out_busy;

    typedef struct packed {logic [15:0] res; logic [3:0] idx; logic dbz;} exp_t;
    exp_t exp_q[$];
    int n_checks = 0, n_fail = 0;

    exec_muldiv_iter #(.IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4), .BITS_PER_CYCLE(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_res_reg_idx(in_res_reg_idx), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_res_reg_idx(out_res_reg_idx), .out_div_by_zero(out_div_by_zero), .out_busy(out_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result handed to writeback is compared against the oldest expectation
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got res %h idx %h dbz %b expected none", out_res, out_res_reg_idx, out_div_by_zero);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_res", out_res, e.res);
                chk("sb_idx", out_res_reg_idx, e.idx);
                chk("sb_dbz", out_div_by_zero, e.dbz);
            end
        end
    end

    // Offer one op, hold it until accepted, optionally record its expected result
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] idx, input logic [15:0] er, input logic ed, input bit push);
        int k = 0;
        in_valid = 1; in_op = op; in_src1 = a; in_src2 = b; in_res_reg_idx = idx;
        @(negedge clock);
        while (!in_ready && k < 100) begin @(negedge clock); k++; end
        chk("accept_ready", in_ready, 1);
        if (push) exp_q.push_back('{res: er, idx: idx, dbz: ed});
        @(posedge clock); #1 in_valid = 0;
    endtask

    // Called right after accept: out_valid must be low in cycle n-1 and high in cycle n
    task automatic lat(input int n);
        if (n > 1) begin
            repeat (n - 1) @(negedge clock);
            chk("lat_before", out_valid, 0);
        end
        @(negedge clock);
        chk("lat_at", out_valid, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_valid", out_valid, 0);
        chk("rst_res", out_res, 0);
        chk("rst_idx", out_res_reg_idx, 0);
        chk("rst_dbz", out_div_by_zero, 0);
        chk("rst_busy", out_busy, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clock); #1;

        issue(3'd0, 16'd300, 16'hFFF9, 4'd1, 16'hF7CC, 0, 1); lat(N + 1);
        issue(3'd1, 16'd300, 16'hFFF9, 4'd2, 16'hFFFF, 0, 1); lat(N + 1);
        issue(3'd2, 16'd300, 16'hFFF9, 4'd3, 16'h012B, 0, 1); lat(N + 1);
        issue(3'd3, 16'hFF9C, 16'd7, 4'd4, 16'hFFF2, 0, 1); lat(N + 1);
        issue(3'd5, 16'hFF9C, 16'd7, 4'd5, 16'hFFFE, 0, 1); lat(N + 1);
        issue(3'd4, 16'hFF9C, 16'd7, 4'd6, 16'h2484, 0, 1); lat(N + 1);
        issue(3'd4, 16'h8000, 16'd0, 4'd7, 16'hFFFF, 1, 1); lat(1);
        issue(3'd6, 16'h8000, 16'd0, 4'd8, 16'h8000, 1, 1); lat(1);
        issue(3'd3, 16'h8000, 16'hFFFF, 4'd9, 16'h8000, 0, 1); lat(N + 1);
        issue(3'd5, 16'h8000, 16'hFFFF, 4'd10, 16'h0000, 0, 1); lat(N + 1);
        issue(3'd7, 16'h1234, 16'h5678, 4'd11, 16'h0000, 0, 1); lat(1);

        issue(3'd0, 16'd5, 16'd5, 4'd12, 16'd25, 0, 0);
        repeat (4) @(posedge clock);
        #1 in_flush = 1;
        @(negedge clock);
        chk("flush_ready_low", in_ready, 0);
        @(posedge clock); #1 in_flush = 0;
        @(negedge clock);
        chk("flush_ready_high", in_ready, 1);
        chk("flush_busy", out_busy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_res", out_res, 0);
        @(posedge clock); #1;
        issue(3'd0, 16'd3, 16'd4, 4'd13, 16'h000C, 0, 1); lat(N + 1);

        out_ready = 0;
        issue(3'd0, 16'd7, 16'd9, 4'd5, 16'h003F, 0, 1);
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clock); k++; end
        chk("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_res_stable", out_res, 16'h003F);
            chk("bp_ready_low", in_ready, 0);
        end
        @(posedge clock); #1 out_ready = 1;
        issue(3'd4, 16'd9, 16'd0, 4'd6, 16'hFFFF, 1, 1);
        @(negedge clock);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_res", out_res, 16'hFFFF);
        chk("b2b_dbz", out_div_by_zero, 1);
        @(posedge clock); #1;

        issue(3'd0, 16'd3, 16'd3, 4'd14, 16'd9, 0, 0);
        repeat (7) @(posedge clock);
        #1 reset = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", out_busy, 0);
        chk("mid_rst_res", out_res, 0);
        chk("mid_rst_idx", out_res_reg_idx, 0);
        chk("mid_rst_dbz", out_div_by_zero, 0);
        @(posedge clock); #1 reset = 0;
        repeat (30) @(negedge clock);
        chk("post_rst_busy", out_busy, 0);
        chk("post_rst_valid", out_valid, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
